rv_multicycle_ctrl: RTL and testbench
=====================================

Name: rv_multicycle_ctrl

Overview:
- Multicycle control FSM for the RV64I datapath.
- Sequences fetch, decode, execute, memory and writeback.
- Drives the ALU operand selects (A-side and the 3-bit B-side mux select), the ALU op, and all register and memory write enables.
- Handshakes with a variable-latency memory and halts on illegal instructions or memory timeout.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles to wait for mem_ready before trapping; must be ≥1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- alu_zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a write
- addr_sel  out  1  0 = PC, 1 = ALUOUT
- ir_write  out  1  latch IR and OLD_PC
- pc_write  out  1  PC load
- pc_src  out  1  0 = ALU result, 1 = ALUOUT
- aluout_write  out  1  ALUOUT load
- mdr_write  out  1  MDR load
- reg_write  out  1  register file write
- wb_sel  out  2  00 = ALUOUT, 01 = MDR, 10 = PC
- sel_a  out  2  00 = PC, 01 = A, 10 = OLD_PC, 11 = zero
- sel_b  out  3  000 = B, 001 = const 4, 010 = sext imm, 011 = sext imm<<1, 100 = upper-imm extensor
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL
- halted  out  1  core stopped in TRAP
- trap_cause  out  2  00 none, 01 illegal, 10 memory timeout

Behaviour:
- **Reset.** While reset is high, all outputs are 0, state goes to FETCH, the timeout counter clears and trap_cause = 00. Reset mid-transaction drops mem_req in the same cycle, with no completion.
- **Output timing.** Outputs are decoded from the state register (Moore). Write enables qualified by mem_ready or alu_zero are Mealy terms in the listed states. Outputs not listed for a state are 0.
- **FETCH.** mem_req=1, addr_sel=0, sel_a=00, sel_b=001, alu_op=ADD.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- **DECODE.** sel_a=10, sel_b=011, ADD, aluout_write=1 (branch/jump target). Dispatch on opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 / 0100011 → MEM_ADDR
  - 1100011 with funct3 ∈ {000, 001} → BRANCH
  - 1101111 → JAL
  - 0110111 → LUI
  - anything else → TRAP with cause 01
- **EXEC_R.** sel_a=01, sel_b=000, aluout_write=1, alu_op from funct3:
  - 000 → ADD if funct7_5 = 0, SUB if funct7_5 = 1
  - 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SLL, 101 SRL
  - 011 → TRAP with cause 01
  - otherwise go to ALU_WB.
- **EXEC_I.** Same as EXEC_R except sel_b=010, and funct3=000 is always ADD (funct7_5 ignored).
- **LUI.** sel_a=11, sel_b=100, ADD, aluout_write=1, then ALU_WB.
- **ALU_WB.** reg_write=1, wb_sel=00, then FETCH.
- **MEM_ADDR.** sel_a=01, sel_b=010, ADD, aluout_write=1. Next is MEM_READ if opcode[5]=0, else MEM_WRITE.
- **MEM_READ.** mem_req=1, addr_sel=1. On mem_ready: mdr_write=1, then MEM_WB.
- **MEM_WB.** reg_write=1, wb_sel=01, then FETCH.
- **MEM_WRITE.** mem_req=1, mem_we=1, addr_sel=1. On mem_ready go to FETCH.
- **BRANCH.** sel_a=01, sel_b=000, SUB.
  - Taken when alu_zero XOR funct3[0]; then pc_write=1, pc_src=1.
  - Always go to FETCH.
- **JAL.** reg_write=1, wb_sel=10 (PC already holds OLD_PC+4), pc_write=1, pc_src=1, then FETCH.
- **TRAP.** halted=1, trap_cause held. Stays in TRAP until reset.
- **Memory wait and timeout.**
  - The wait counter clears on entry to FETCH, MEM_READ or MEM_WRITE and increments each cycle mem_ready=0 in those states.
  - When counter == MEM_TIMEOUT-1 and mem_ready=0: go to TRAP, cause 10, and drop mem_req the next cycle.
  - mem_ready on the same cycle as the timeout takes priority: the transaction completes normally.
  - mem_ready outside a request state is ignored.
- **Latencies** with zero-wait memory, in cycles: R/I/LUI 4, LD 5, SD 4, branch 3, JAL 3.

Decomposition:
- Shared package `rv_ctrl_pkg`:
  - state enum
  - opcode constants
  - alu_op, sel_a, sel_b and wb_sel enums (sel_b codes shared with the ALU B-mux)
  - trap_cause codes
- Sub-module `rv_alu_decode`: combinational funct3/funct7_5 → alu_op plus an illegal flag.

Test Plan:
- Reset held 3 cycles mid MEM_READ → mem_req=0 immediately; after release, FETCH with sel_b=001 and sel_a=00.
- ADD then SUB (opcode 0110011, funct3 000, funct7_5 0/1), mem_ready always 1 → 4 cycles each; alu_op 000 then 001 in EXEC_R; reg_write pulses once with wb_sel=00.
- LD with mem_ready delayed 3 cycles in MEM_READ → mem_req, addr_sel=1 held 4 cycles; mdr_write only on the ready cycle; MEM_WB reg_write with wb_sel=01; total 8 cycles.
- BNE (funct3 001) with alu_zero=0, then BEQ with alu_zero=0 → first: pc_write=1, pc_src=1 in BRANCH; second: pc_write=0.
- opcode 1111111, and separately R-type funct3 011 → TRAP, halted=1, trap_cause=01, held for 20 cycles until reset.
- MEM_TIMEOUT=4, mem_ready stuck at 0 in FETCH → TRAP after the 4th request cycle, cause 10. Repeat with mem_ready=1 on the 4th cycle → normal DECODE.

Source files
------------

// File: rtl/rv_multicycle_ctrl_pkg.sv
// Shared state, opcode and control-field encodings for the RV64I multicycle controller.
// The sel_b codes are also the select encoding of the datapath ALU B-side mux.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_EXEC_R    = 4'd2,
    ST_EXEC_I    = 4'd3,
    ST_LUI       = 4'd4,
    ST_ALU_WB    = 4'd5,
    ST_MEM_ADDR  = 4'd6,
    ST_MEM_READ  = 4'd7,
    ST_MEM_WB    = 4'd8,
    ST_MEM_WRITE = 4'd9,
    ST_BRANCH    = 4'd10,
    ST_JAL       = 4'd11,
    ST_TRAP      = 4'd12
  } state_e;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SEL_A_PC     = 2'b00,
    SEL_A_REG    = 2'b01,
    SEL_A_OLD_PC = 2'b10,
    SEL_A_ZERO   = 2'b11
  } sel_a_e;

  typedef enum logic [2:0] {
    SEL_B_REG     = 3'b000,
    SEL_B_FOUR    = 3'b001,
    SEL_B_IMM     = 3'b010,
    SEL_B_IMM_SH1 = 3'b011,
    SEL_B_UPPER   = 3'b100
  } sel_b_e;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'b00,
    WB_MDR    = 2'b01,
    WB_PC     = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    TRAP_NONE        = 2'b00,
    TRAP_ILLEGAL     = 2'b01,
    TRAP_MEM_TIMEOUT = 2'b10
  } trap_cause_e;

  // Full control word presented to the datapath each cycle.
  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        aluout_write;
    logic        mdr_write;
    logic        reg_write;
    wb_sel_e     wb_sel;
    sel_a_e      sel_a;
    sel_b_e      sel_b;
    alu_op_e     alu_op;
    logic        halted;
    trap_cause_e trap_cause;
  } ctrl_word_t;

  // States that hold a memory request open and run the timeout counter.
  function automatic logic is_mem_wait_state(state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
  endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle.
// master = controller side, slave = datapath side.
interface rv_multicycle_ctrl_if;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       alu_zero;
  logic       mem_ready;

  logic       mem_req;
  logic       mem_we;
  logic       addr_sel;
  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic       aluout_write;
  logic       mdr_write;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic [1:0] sel_a;
  logic [2:0] sel_b;
  logic [2:0] alu_op;
  logic       halted;
  logic [1:0] trap_cause;

  modport master (
    input  opcode, funct3, funct7_5, alu_zero, mem_ready,
    output mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
           aluout_write, mdr_write, reg_write, wb_sel, sel_a, sel_b,
           alu_op, halted, trap_cause
  );

  modport slave (
    output opcode, funct3, funct7_5, alu_zero, mem_ready,
    input  mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
           aluout_write, mdr_write, reg_write, wb_sel, sel_a, sel_b,
           alu_op, halted, trap_cause
  );

endinterface

// File: rtl/rv_multicycle_ctrl_alu_decode.sv
// funct3/funct7_5 to ALU operation for R- and I-type arithmetic.
// funct3 = 011 (SLTU) is not supported and is flagged illegal.
module rv_alu_decode
  import rv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       allow_sub,
  output alu_op_e    alu_op_c,
  output logic       illegal_c
);

  always_comb begin
    alu_op_c  = ALU_ADD;
    illegal_c = 1'b0;
    case (funct3)
      3'b000:  alu_op_c = (allow_sub && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op_c = ALU_SLL;
      3'b010:  alu_op_c = ALU_SLT;
      3'b011:  illegal_c = 1'b1;
      3'b100:  alu_op_c = ALU_XOR;
      3'b101:  alu_op_c = ALU_SRL;
      3'b110:  alu_op_c = ALU_OR;
      default: alu_op_c = ALU_AND;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle fetch/decode/execute/memory/writeback controller for the RV64I datapath.
// Moore control word from the state register, with mem_ready/alu_zero-qualified write enables.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  rv_multicycle_ctrl_if.master bus
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  trap_cause_e      cause_q, cause_d;
  ctrl_word_t       ctrl_c, out_c;
  logic             waiting_c;
  alu_op_e          dec_op_c;
  logic             dec_illegal_c;

  rv_alu_decode u_alu_decode (
    .funct3    (bus.funct3),
    .funct7_5  (bus.funct7_5),
    .allow_sub (state_q == ST_EXEC_R),
    .alu_op_c  (dec_op_c),
    .illegal_c (dec_illegal_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      wait_cnt_q <= '0;
      cause_q    <= TRAP_NONE;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cause_q    <= cause_d;
    end
  end

  // Next state and control word.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    cause_d    = cause_q;
    ctrl_c     = '0;
    waiting_c  = 1'b0;

    case (state_q)
      ST_FETCH: begin
        ctrl_c.mem_req = 1'b1;
        ctrl_c.sel_a   = SEL_A_PC;
        ctrl_c.sel_b   = SEL_B_FOUR;
        ctrl_c.alu_op  = ALU_ADD;
        waiting_c      = 1'b1;
        if (bus.mem_ready) begin
          ctrl_c.ir_write = 1'b1;
          ctrl_c.pc_write = 1'b1;
          state_d         = ST_DECODE;
        end
      end

      ST_DECODE: begin
        ctrl_c.sel_a        = SEL_A_OLD_PC;
        ctrl_c.sel_b        = SEL_B_IMM_SH1;
        ctrl_c.alu_op       = ALU_ADD;
        ctrl_c.aluout_write = 1'b1;
        case (bus.opcode)
          OP_R_TYPE:         state_d = ST_EXEC_R;
          OP_I_TYPE:         state_d = ST_EXEC_I;
          OP_LOAD, OP_STORE: state_d = ST_MEM_ADDR;
          OP_BRANCH:         state_d = (bus.funct3[2:1] == 2'b00) ? ST_BRANCH : ST_TRAP;
          OP_JAL:            state_d = ST_JAL;
          OP_LUI:            state_d = ST_LUI;
          default:           state_d = ST_TRAP;
        endcase
        if (state_d == ST_TRAP) cause_d = TRAP_ILLEGAL;
      end

      ST_EXEC_R, ST_EXEC_I: begin
        ctrl_c.sel_a        = SEL_A_REG;
        ctrl_c.sel_b        = (state_q == ST_EXEC_R) ? SEL_B_REG : SEL_B_IMM;
        ctrl_c.alu_op       = dec_op_c;
        ctrl_c.aluout_write = 1'b1;
        if (dec_illegal_c) begin
          state_d = ST_TRAP;
          cause_d = TRAP_ILLEGAL;
        end else begin
          state_d = ST_ALU_WB;
        end
      end

      ST_LUI: begin
        ctrl_c.sel_a        = SEL_A_ZERO;
        ctrl_c.sel_b        = SEL_B_UPPER;
        ctrl_c.alu_op       = ALU_ADD;
        ctrl_c.aluout_write = 1'b1;
        state_d             = ST_ALU_WB;
      end

      ST_ALU_WB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.wb_sel    = WB_ALUOUT;
        state_d          = ST_FETCH;
      end

      ST_MEM_ADDR: begin
        ctrl_c.sel_a        = SEL_A_REG;
        ctrl_c.sel_b        = SEL_B_IMM;
        ctrl_c.alu_op       = ALU_ADD;
        ctrl_c.aluout_write = 1'b1;
        state_d             = bus.opcode[5] ? ST_MEM_WRITE : ST_MEM_READ;
      end

      ST_MEM_READ: begin
        ctrl_c.mem_req  = 1'b1;
        ctrl_c.addr_sel = 1'b1;
        waiting_c       = 1'b1;
        if (bus.mem_ready) begin
          ctrl_c.mdr_write = 1'b1;
          state_d          = ST_MEM_WB;
        end
      end

      ST_MEM_WB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.wb_sel    = WB_MDR;
        state_d          = ST_FETCH;
      end

      ST_MEM_WRITE: begin
        ctrl_c.mem_req  = 1'b1;
        ctrl_c.mem_we   = 1'b1;
        ctrl_c.addr_sel = 1'b1;
        waiting_c       = 1'b1;
        if (bus.mem_ready) state_d = ST_FETCH;
      end

      ST_BRANCH: begin
        ctrl_c.sel_a  = SEL_A_REG;
        ctrl_c.sel_b  = SEL_B_REG;
        ctrl_c.alu_op = ALU_SUB;
        // funct3[0] inverts the zero test: BEQ on zero, BNE on non-zero.
        if (bus.alu_zero ^ bus.funct3[0]) begin
          ctrl_c.pc_write = 1'b1;
          ctrl_c.pc_src   = 1'b1;
        end
        state_d = ST_FETCH;
      end

      ST_JAL: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.wb_sel    = WB_PC;
        ctrl_c.pc_write  = 1'b1;
        ctrl_c.pc_src    = 1'b1;
        state_d          = ST_FETCH;
      end

      default: begin
        ctrl_c.halted     = 1'b1;
        ctrl_c.trap_cause = cause_q;
      end
    endcase

    // Completion on the last allowed cycle wins over the timeout.
    if (waiting_c && !bus.mem_ready) begin
      if (wait_cnt_q == CNT_LAST) begin
        state_d = ST_TRAP;
        cause_d = TRAP_MEM_TIMEOUT;
      end else begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end

    if ((state_d != state_q) && is_mem_wait_state(state_d)) wait_cnt_d = '0;
  end

  // Reset forces the whole control word low in the same cycle.
  always_comb begin
    out_c = ctrl_c;
    if (reset) out_c = '0;
  end

  assign bus.mem_req      = out_c.mem_req;
  assign bus.mem_we       = out_c.mem_we;
  assign bus.addr_sel     = out_c.addr_sel;
  assign bus.ir_write     = out_c.ir_write;
  assign bus.pc_write     = out_c.pc_write;
  assign bus.pc_src       = out_c.pc_src;
  assign bus.aluout_write = out_c.aluout_write;
  assign bus.mdr_write    = out_c.mdr_write;
  assign bus.reg_write    = out_c.reg_write;
  assign bus.wb_sel       = out_c.wb_sel;
  assign bus.sel_a        = out_c.sel_a;
  assign bus.sel_b        = out_c.sel_b;
  assign bus.alu_op       = out_c.alu_op;
  assign bus.halted       = out_c.halted;
  assign bus.trap_cause   = out_c.trap_cause;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench: an instruction-level model expands each instruction into its
// expected per-cycle control words; a monitor compares them against the DUT.
module tb_rv_multicycle_ctrl;

  localparam int T = 4;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       aluout_write;
    logic       mdr_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [1:0] sel_a;
    logic [2:0] sel_b;
    logic [2:0] alu_op;
    logic       halted;
    logic [1:0] trap_cause;
  } ctl_t;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       zero;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    ctl_t       exp;
    ctl_t       mask;
    string      name;
  } step_t;

  typedef struct {
    ctl_t  exp;
    ctl_t  mask;
    string name;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv_multicycle_ctrl_if bus();

  rv_multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  step_t      plan[$];
  sb_t        sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cycle  = 0;
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;
  ctl_t       mask_all;
  ctl_t       mask_no_alu;

  function automatic ctl_t sample();
    ctl_t g;
    g.mem_req      = bus.mem_req;
    g.mem_we       = bus.mem_we;
    g.addr_sel     = bus.addr_sel;
    g.ir_write     = bus.ir_write;
    g.pc_write     = bus.pc_write;
    g.pc_src       = bus.pc_src;
    g.aluout_write = bus.aluout_write;
    g.mdr_write    = bus.mdr_write;
    g.reg_write    = bus.reg_write;
    g.wb_sel       = bus.wb_sel;
    g.sel_a        = bus.sel_a;
    g.sel_b        = bus.sel_b;
    g.alu_op       = bus.alu_op;
    g.halted       = bus.halted;
    g.trap_cause   = bus.trap_cause;
    return g;
  endfunction

  // ALU operation table for arithmetic funct3 codes (011 handled as illegal).
  function automatic logic [2:0] ref_alu_op(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? 3'b001 : 3'b000;
      3'b001:  return 3'b110;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b101:  return 3'b111;
      3'b110:  return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  task automatic emit(input logic rst, input logic rdy, input logic zero,
                      input ctl_t e, input ctl_t m, input string nm);
    step_t s;
    s.rst = rst; s.rdy = rdy; s.zero = zero;
    s.op = cur_op; s.f3 = cur_f3; s.f7 = cur_f7;
    s.exp = e; s.mask = m; s.name = nm;
    plan.push_back(s);
  endtask

  task automatic emit_x(input ctl_t e, input string nm);
    emit(1'b0, 1'($urandom), 1'($urandom), e, mask_all, nm);
  endtask

  // Memory handshake: wait_n idle cycles then ready, or trap after T idle cycles.
  task automatic mem_phase(input ctl_t base, input ctl_t done, input int wait_n,
                           input string nm, output bit timed_out);
    timed_out = 1'b0;
    for (int k = 0; k < T; k++) begin
      if (k == wait_n) begin
        emit(1'b0, 1'b1, 1'($urandom), done, mask_all, nm);
        return;
      end
      emit(1'b0, 1'b0, 1'($urandom), base, mask_all, nm);
    end
    timed_out = 1'b1;
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) emit(1'b1, 1'($urandom), 1'($urandom), '0, mask_all, "reset");
  endtask

  task automatic trap_reset(input logic [1:0] cause, input int n);
    ctl_t t;
    t = '0; t.halted = 1'b1; t.trap_cause = cause;
    for (int i = 0; i < n; i++) emit_x(t, "trap");
    reset_cycles(2);
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int fwait, input int mwait, input logic zero, input int tlen);
    ctl_t b, d;
    bit   to;
    cur_op = op; cur_f3 = f3; cur_f7 = f7;
    b = '0; b.mem_req = 1'b1; b.sel_b = 3'b001;
    d = b; d.ir_write = 1'b1; d.pc_write = 1'b1;
    mem_phase(b, d, fwait, "fetch", to);
    if (to) begin trap_reset(2'b10, tlen); return; end
    b = '0; b.sel_a = 2'b10; b.sel_b = 3'b011; b.aluout_write = 1'b1;
    emit_x(b, "decode");
    case (op)
      7'b0110011, 7'b0010011: begin
        b = '0; b.sel_a = 2'b01; b.aluout_write = 1'b1;
        b.sel_b = (op == 7'b0110011) ? 3'b000 : 3'b010;
        if (f3 == 3'b011) begin
          emit(1'b0, 1'($urandom), 1'($urandom), b, mask_no_alu, "exec_illegal");
          trap_reset(2'b01, tlen);
        end else begin
          b.alu_op = ref_alu_op(f3, (op == 7'b0110011) && f7);
          emit_x(b, "exec");
          b = '0; b.reg_write = 1'b1; emit_x(b, "alu_wb");
        end
      end
      7'b0110111: begin
        b = '0; b.sel_a = 2'b11; b.sel_b = 3'b100; b.aluout_write = 1'b1;
        emit_x(b, "lui");
        b = '0; b.reg_write = 1'b1; emit_x(b, "alu_wb");
      end
      7'b0000011, 7'b0100011: begin
        b = '0; b.sel_a = 2'b01; b.sel_b = 3'b010; b.aluout_write = 1'b1;
        emit_x(b, "mem_addr");
        b = '0; b.mem_req = 1'b1; b.addr_sel = 1'b1;
        if (op == 7'b0000011) begin
          d = b; d.mdr_write = 1'b1;
          mem_phase(b, d, mwait, "mem_read", to);
          if (to) trap_reset(2'b10, tlen);
          else begin b = '0; b.reg_write = 1'b1; b.wb_sel = 2'b01; emit_x(b, "mem_wb"); end
        end else begin
          b.mem_we = 1'b1;
          mem_phase(b, b, mwait, "mem_write", to);
          if (to) trap_reset(2'b10, tlen);
        end
      end
      7'b1100011: begin
        if (f3 == 3'b000 || f3 == 3'b001) begin
          b = '0; b.sel_a = 2'b01; b.sel_b = 3'b000; b.alu_op = 3'b001;
          if (zero != f3[0]) begin b.pc_write = 1'b1; b.pc_src = 1'b1; end
          emit(1'b0, 1'($urandom), zero, b, mask_all, "branch");
        end else begin
          trap_reset(2'b01, tlen);
        end
      end
      7'b1101111: begin
        b = '0; b.reg_write = 1'b1; b.wb_sel = 2'b10; b.pc_write = 1'b1; b.pc_src = 1'b1;
        emit_x(b, "jal");
      end
      default: trap_reset(2'b01, tlen);
    endcase
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return T;
    if (r == 1) return T - 1;
    return int'($urandom_range(0, 2));
  endfunction

  // Monitor: one expected control word per cycle, sampled mid-cycle.
  initial begin
    sb_t  e;
    ctl_t g;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        g = sample();
        checks++;
        if ((g & e.mask) !== (e.exp & e.mask)) begin
          errors++;
          $display("FAIL %s cycle %0d: got %h required %h (mask %h)", e.name, cycle, g, e.exp, e.mask);
        end
      end
    end
  end

  initial begin
    step_t      s;
    sb_t        e;
    int         start, r;
    logic [6:0] op;
    logic [2:0] f3;

    reset = 1'b1;
    bus.opcode = '0; bus.funct3 = '0; bus.funct7_5 = 1'b0;
    bus.alu_zero = 1'b0; bus.mem_ready = 1'b0;
    mask_all = '1;
    mask_no_alu = '1; mask_no_alu.alu_op = 3'b000;
    cur_op = '0; cur_f3 = '0; cur_f7 = 1'b0;

    reset_cycles(3);
    run_instr(7'b0110011, 3'b000, 1'b0, 0, 0, 1'b0, 1);   // ADD
    run_instr(7'b0110011, 3'b000, 1'b1, 0, 0, 1'b0, 1);   // SUB
    run_instr(7'b0010011, 3'b000, 1'b1, 0, 0, 1'b0, 1);   // ADDI ignores funct7_5
    run_instr(7'b0000011, 3'b011, 1'b0, 0, 3, 1'b0, 1);   // LD, 3 wait cycles
    run_instr(7'b0100011, 3'b011, 1'b0, 1, 2, 1'b0, 1);   // SD
    run_instr(7'b1100011, 3'b001, 1'b0, 0, 0, 1'b0, 1);   // BNE taken
    run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 1'b0, 1);   // BEQ not taken
    run_instr(7'b1101111, 3'b000, 1'b0, 0, 0, 1'b0, 1);   // JAL
    run_instr(7'b0110111, 3'b000, 1'b0, 0, 0, 1'b0, 1);   // LUI
    run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0, 20);  // illegal opcode
    run_instr(7'b0110011, 3'b011, 1'b0, 0, 0, 1'b0, 20);  // illegal funct3
    run_instr(7'b0110011, 3'b100, 1'b0, T, 0, 1'b0, 3);   // fetch timeout
    run_instr(7'b0110011, 3'b100, 1'b0, T - 1, 0, 1'b0, 3); // ready on the last cycle
    run_instr(7'b0000011, 3'b011, 1'b0, 0, T, 1'b0, 3);   // load timeout
    start = plan.size();
    run_instr(7'b0000011, 3'b011, 1'b0, 0, 3, 1'b0, 1);   // reset inside MEM_READ
    while (plan.size() > start + 4) void'(plan.pop_back());
    reset_cycles(3);

    for (int n = 0; n < 250; n++) begin
      r  = int'($urandom_range(0, 99));
      f3 = 3'($urandom);
      if      (r < 20) op = 7'b0110011;
      else if (r < 35) op = 7'b0010011;
      else if (r < 45) op = 7'b0110111;
      else if (r < 60) op = 7'b0000011;
      else if (r < 72) op = 7'b0100011;
      else if (r < 84) begin
        op = 7'b1100011;
        if ($urandom_range(0, 9) != 0) f3 = {2'b00, 1'($urandom)};
      end
      else if (r < 92) op = 7'b1101111;
      else op = 7'($urandom);
      run_instr(op, f3, 1'($urandom), pick_wait(), pick_wait(), 1'($urandom),
                int'($urandom_range(1, 6)));
    end

    while (plan.size() > 0) begin
      s = plan.pop_front();
      @(posedge clk);
      #1;
      cycle++;
      reset        = s.rst;
      bus.mem_ready = s.rdy;
      bus.alu_zero = s.zero;
      bus.opcode   = s.op;
      bus.funct3   = s.f3;
      bus.funct7_5 = s.f7;
      e.exp = s.exp; e.mask = s.mask; e.name = s.name;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
